// File: rtl/aibnd_txgbx.sv
`default_nettype none
// aibnd_txgbx: AIB transmit gearbox, W-bit words in, one DDR bit pair out per launch clock.
// Also emits clock / PRBS7 / zero training patterns. Revision 1.0
module aibnd_txgbx #(
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         ilaunch_clk,
  input  logic         irstb,
  input  logic [W-1:0] idata,
  input  logic         ivalid,
  output logic         oready,
  input  logic [1:0]   imode,
  input  logic         iclr_err,
  output logic         odat0,
  output logic         odat1,
  output logic         odat_vld,
  output logic         oword_start,
  output logic         ounderflow
);

  localparam int B  = W / 2;
  localparam int CW = $clog2(B);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);
  localparam logic [CW-1:0] ONE_BEAT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR   = AW'(1);
  localparam logic [NW-1:0] ONE_CNT   = NW'(1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  localparam logic [1:0] MODE_DATA = 2'b00;
  localparam logic [1:0] MODE_CLK  = 2'b01;
  localparam logic [1:0] MODE_PRBS = 2'b10;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          ready;
  logic [CW-1:0] beat;
  logic [W-1:0]  shreg;
  logic [6:0]    lfsr;
  logic [1:0]    mode;
  logic [1:0]    pair;
  logic          vld, wstart, uflow, popped;

  logic          boundary, push, pop, starve;
  logic [1:0]    eff_mode, pair_nxt;
  logic [W-1:0]  head, shreg_nxt;
  logic [NW-1:0] count_nxt;
  logic [6:0]    lfsr_mid, lfsr_nxt;

  assign head = mem[rd_ptr];

  always_comb begin
    boundary  = (beat == LAST_BEAT);
    push      = ivalid & ready;
    pop       = boundary && (imode == MODE_DATA) && (count != '0);
    starve    = boundary && (imode == MODE_DATA) && (count == '0);
    // The beat launched at a boundary already belongs to the new slot's mode.
    eff_mode  = boundary ? imode : mode;

    count_nxt = count;
    if (push && !pop)
      count_nxt = count + ONE_CNT;
    else if (pop && !push)
      count_nxt = count - ONE_CNT;

    lfsr_mid  = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    lfsr_nxt  = {lfsr_mid[5:0], lfsr_mid[6] ^ lfsr_mid[5]};

    shreg_nxt = boundary ? (pop ? (head >> 2) : '0) : (shreg >> 2);

    pair_nxt  = 2'b00;
    case (eff_mode)
      MODE_DATA: pair_nxt = boundary ? (pop ? head[1:0] : 2'b00) : shreg[1:0];
      MODE_CLK:  pair_nxt = 2'b01;
      MODE_PRBS: pair_nxt = {lfsr_nxt[0], lfsr_mid[0]};
      default:   pair_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge ilaunch_clk) begin
    if (push)
      mem[wr_ptr] <= idata;
  end

  always_ff @(posedge ilaunch_clk or negedge irstb) begin
    if (!irstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
      beat   <= '0;
      shreg  <= '0;
      lfsr   <= 7'h7F;
      mode   <= MODE_DATA;
      pair   <= 2'b00;
      vld    <= 1'b0;
      wstart <= 1'b0;
      uflow  <= 1'b0;
      popped <= 1'b0;
    end else begin
      beat   <= boundary ? '0 : beat + ONE_BEAT;
      count  <= count_nxt;
      ready  <= (count_nxt != FULL_CNT);
      if (push)
        wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)
        rd_ptr <= rd_ptr + ONE_PTR;
      shreg  <= shreg_nxt;
      pair   <= pair_nxt;
      wstart <= boundary;
      if (boundary) begin
        mode <= imode;
        vld  <= pop;
      end
      if (eff_mode == MODE_PRBS)
        lfsr <= lfsr_nxt;
      // A fresh underflow beats a simultaneous clear.
      if (starve && popped)
        uflow <= 1'b1;
      else if (iclr_err)
        uflow <= 1'b0;
      if (pop)
        popped <= 1'b1;
      else if (iclr_err)
        popped <= 1'b0;
    end
  end

  assign oready      = ready;
  assign odat0       = pair[0];
  assign odat1       = pair[1];
  assign odat_vld    = vld;
  assign oword_start = wstart;
  assign ounderflow  = uflow;

endmodule
`default_nettype wire

// File: tb/tb_aibnd_txgbx.sv
`default_nettype none
// tb_aibnd_txgbx: directed self-checking bench for the AIB transmit gearbox.
module tb_aibnd_txgbx;

  logic       clk = 1'b0;
  logic       irstb;
  logic [7:0] idata;
  logic       ivalid;
  logic [1:0] imode;
  logic       iclr_err;
  logic       oready, odat0, odat1, odat_vld, oword_start, ounderflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aibnd_txgbx #(.W(8), .FIFO_DEPTH(2)) dut (
    .ilaunch_clk (clk),
    .irstb       (irstb),
    .idata       (idata),
    .ivalid      (ivalid),
    .oready      (oready),
    .imode       (imode),
    .iclr_err    (iclr_err),
    .odat0       (odat0),
    .odat1       (odat1),
    .odat_vld    (odat_vld),
    .oword_start (oword_start),
    .ounderflow  (ounderflow)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Returns at the negedge where irstb is released; the next posedge is edge E1.
  task automatic do_reset(input logic [1:0] mode);
    @(negedge clk);
    irstb = 1'b0; ivalid = 1'b0; idata = 8'h00; imode = mode; iclr_err = 1'b0;
    repeat (2) @(negedge clk);
    irstb = 1'b1;
  endtask

  task automatic test_reset();
    irstb = 1'b0; ivalid = 1'b0; idata = 8'hFF; imode = 2'b00; iclr_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({oready, ounderflow, odat_vld, oword_start, odat1, odat0} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {oready, ounderflow, odat_vld, oword_start, odat1, odat0});
    end
    irstb = 1'b1;
    checks++;
    if (oready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b expected 0", oready);
    end
    tick();
    checks++;
    if (oready !== 1'b1) begin
      errors++; $display("FAIL ready_after_release: got %b expected 1", oready);
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp_pair [4];
    logic [3:0] expv;
    exp_pair = '{2'b00, 2'b01, 2'b11, 2'b10};  // {odat1,odat0} for 8'hB4
    do_reset(2'b00);
    tick();                                    // E1
    idata = 8'hB4; ivalid = 1'b1;
    tick();                                    // E2: accepted
    ivalid = 1'b0;
    tick();                                    // E3
    checks++;
    if (odat_vld !== 1'b0) begin
      errors++; $display("FAIL basic_latency: vld got %b expected 0", odat_vld);
    end
    for (int k = 0; k < 4; k++) begin
      tick();                                  // E4..E7
      expv = {1'b1, (k == 0), exp_pair[k]};
      checks++;
      if ({odat_vld, oword_start, odat1, odat0} !== expv) begin
        errors++;
        $display("FAIL basic_beat%0d: got %b expected %b", k,
                 {odat_vld, oword_start, odat1, odat0}, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3];
    logic [11:0] exp_d0, exp_d1;
    logic        go;
    int          idx, j;
    words  = '{8'h00, 8'hFF, 8'hA5};
    exp_d0 = 12'b0011_1111_0000;
    exp_d1 = 12'b1100_1111_0000;
    do_reset(2'b00);
    tick();                                    // E1
    idx = 0; idata = words[0]; ivalid = 1'b1;
    for (int e = 2; e <= 15; e++) begin
      go = ivalid & oready;
      tick();
      if (go) idx++;
      if (idx < 3) idata = words[idx];
      else ivalid = 1'b0;
      if (e >= 4) begin
        j = e - 4;
        checks++;
        if ({ounderflow, odat_vld, odat1, odat0} !== {1'b0, 1'b1, exp_d1[j], exp_d0[j]}) begin
          errors++;
          $display("FAIL b2b_beat%0d: got %b expected %b", j,
                   {ounderflow, odat_vld, odat1, odat0}, {1'b0, 1'b1, exp_d1[j], exp_d0[j]});
        end
      end
    end
    checks++;
    if (idx !== 3) begin
      errors++; $display("FAIL b2b_accepts: got %0d expected 3", idx);
    end
  endtask

  task automatic test_underflow();
    do_reset(2'b00);
    tick();                                    // E1
    idata = 8'hB4; ivalid = 1'b1;
    tick();                                    // E2
    ivalid = 1'b0;
    repeat (5) tick();                         // E3..E7
    checks++;
    if (ounderflow !== 1'b0) begin
      errors++; $display("FAIL uflow_before: got %b expected 0", ounderflow);
    end
    tick();                                    // E8: empty slot
    checks++;
    if ({ounderflow, odat_vld, odat1, odat0} !== 4'b1000) begin
      errors++;
      $display("FAIL uflow_set: got %b expected 1000", {ounderflow, odat_vld, odat1, odat0});
    end
    repeat (3) tick();                         // E9..E11
    checks++;
    if (ounderflow !== 1'b1) begin
      errors++; $display("FAIL uflow_sticky: got %b expected 1", ounderflow);
    end
    iclr_err = 1'b1;
    tick();                                    // E12: new underflow with clear
    checks++;
    if (ounderflow !== 1'b1) begin
      errors++; $display("FAIL uflow_set_priority: got %b expected 1", ounderflow);
    end
    tick();                                    // E13: clear alone
    checks++;
    if (ounderflow !== 1'b0) begin
      errors++; $display("FAIL uflow_clear: got %b expected 0", ounderflow);
    end
    iclr_err = 1'b0;
    repeat (3) tick();                         // E14..E16: qualifier re-armed
    checks++;
    if ({ounderflow, odat_vld} !== 2'b00) begin
      errors++; $display("FAIL uflow_rearm: got %b expected 00", {ounderflow, odat_vld});
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_d0, exp_d1;
    logic [4:0]  expv;
    int          j;
    exp_d0 = 12'b0101_0000_0101;               // words 8'h11, 8'h22, 8'h33
    exp_d1 = 12'b0101_0101_0000;
    do_reset(2'b01);
    tick();                                    // E1
    idata = 8'h11; ivalid = 1'b1;
    tick();                                    // E2
    idata = 8'h22;
    tick();                                    // E3: FIFO full
    idata = 8'h33;
    checks++;
    if (oready !== 1'b0) begin
      errors++; $display("FAIL bp_full: ready got %b expected 0", oready);
    end
    for (int e = 4; e <= 7; e++) begin
      tick();
      expv = {1'b0, 1'b0, (e == 4), 2'b01};
      checks++;
      if ({oready, odat_vld, oword_start, odat1, odat0} !== expv) begin
        errors++;
        $display("FAIL bp_clk_pattern_e%0d: got %b expected %b", e,
                 {oready, odat_vld, oword_start, odat1, odat0}, expv);
      end
    end
    imode = 2'b00;
    for (int e = 8; e <= 19; e++) begin
      tick();
      j = e - 8;
      if (e == 8) begin
        checks++;
        if (oready !== 1'b1) begin
          errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", oready);
        end
      end
      if (e == 9) ivalid = 1'b0;               // third word taken at E9
      expv = {1'b1, ((j % 4) == 0), exp_d1[j], exp_d0[j], 1'b0};
      checks++;
      if ({odat_vld, oword_start, odat1, odat0, 1'b0} !== expv) begin
        errors++;
        $display("FAIL bp_beat%0d: got %b expected %b", j,
                 {odat_vld, oword_start, odat1, odat0}, expv[4:1]);
      end
    end
  endtask

  task automatic test_prbs();
    logic       seq [528];
    logic [1:0] expp;
    logic [3:0] hand_d0;
    int         m;
    hand_d0 = 4'b1000;
    for (int i = 0; i < 7; i++) seq[i] = 1'b1;
    for (int n = 0; n < 521; n++) seq[n + 7] = seq[n] ^ seq[n + 1];
    do_reset(2'b10);
    repeat (3) tick();                         // E1..E3: mode register still data
    checks++;
    if ({odat_vld, odat1, odat0} !== 3'b000) begin
      errors++; $display("FAIL prbs_pre: got %b expected 000", {odat_vld, odat1, odat0});
    end
    m = 0;
    for (int r = 0; r < 264; r++) begin
      tick();
      if (r < 256 || r >= 260) begin
        expp = {seq[7 + 2 * m + 1], seq[7 + 2 * m]};
        m++;
      end else begin
        expp = 2'b00;
      end
      checks++;
      if ({odat_vld, odat1, odat0} !== {1'b0, expp}) begin
        errors++;
        $display("FAIL prbs_cycle%0d: got %b expected %b", r,
                 {odat_vld, odat1, odat0}, {1'b0, expp});
      end
      if (r < 4) begin
        checks++;
        if ({odat1, odat0} !== {1'b0, hand_d0[r]}) begin
          errors++;
          $display("FAIL prbs_first%0d: got %b expected %b", r,
                   {odat1, odat0}, {1'b0, hand_d0[r]});
        end
      end
      if (r == 255) imode = 2'b11;
      if (r == 259) imode = 2'b10;
    end
  endtask

  task automatic test_reset_midword();
    logic [1:0] c3_pair [4];
    logic [3:0] expv;
    c3_pair = '{2'b11, 2'b00, 2'b00, 2'b11};   // {odat1,odat0} for 8'hC3
    do_reset(2'b00);
    tick();                                    // E1
    idata = 8'hB4; ivalid = 1'b1;
    tick();                                    // E2
    idata = 8'h5A;
    tick();                                    // E3: 5A queued behind B4
    ivalid = 1'b0;
    repeat (3) tick();                         // E4..E6: beat 2 of B4
    checks++;
    if ({odat_vld, odat1, odat0} !== 3'b111) begin
      errors++; $display("FAIL rm_beat2: got %b expected 111", {odat_vld, odat1, odat0});
    end
    #1 irstb = 1'b0;
    #1;
    checks++;
    if ({oready, ounderflow, odat_vld, oword_start, odat1, odat0} !== 6'b000000) begin
      errors++;
      $display("FAIL rm_async: got %b expected 000000",
               {oready, ounderflow, odat_vld, oword_start, odat1, odat0});
    end
    tick();
    tick();
    irstb = 1'b1;
    tick();                                    // E1'
    checks++;
    if (oready !== 1'b1) begin
      errors++; $display("FAIL rm_ready: got %b expected 1", oready);
    end
    idata = 8'hC3; ivalid = 1'b1;
    tick();                                    // E2'
    ivalid = 1'b0;
    tick();                                    // E3'
    for (int k = 0; k < 4; k++) begin
      tick();                                  // E4'..E7'
      expv = {1'b1, (k == 0), c3_pair[k]};
      checks++;
      if ({odat_vld, oword_start, odat1, odat0} !== expv) begin
        errors++;
        $display("FAIL rm_beat%0d: got %b expected %b", k,
                 {odat_vld, oword_start, odat1, odat0}, expv);
      end
    end
    tick();                                    // E8': no stale word left behind
    checks++;
    if ({ounderflow, odat_vld, odat1, odat0} !== 4'b1000) begin
      errors++;
      $display("FAIL rm_fifo_empty: got %b expected 1000", {ounderflow, odat_vld, odat1, odat0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underflow();
    test_backpressure();
    test_prbs();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
